// File: rtl/store_buffer.sv
// store_buffer: FIFO write buffer between the CPU memory stage and data_mem.
// Stores queue up and drain one per cycle. Loads have priority on the shared
// memory port, except when the buffer is full.
// Optional feature macro: STORE_FWD_EN. When it is defined, a load that is
// fully covered by the youngest overlapping store is forwarded from that store.
module store_buffer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDRESS_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0]    st_data,
  input  logic [2:0]               st_funct3,
  input  logic                     ld_valid,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  input  logic [2:0]               ld_funct3,
  output logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     ld_stall,
  input  logic                     fence_req,
  output logic                     fence_done,
  output logic                     empty,
  output logic                     mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [2:0]               mem_funct3,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {RUN, FENCE, DONE} state_t;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] entry_addr   [DEPTH];
  logic [DATA_WIDTH-1:0]    entry_data   [DEPTH];
  logic [2:0]               entry_funct3 [DEPTH];
  logic [PTR_W-1:0]         head, tail, scan_idx;
  logic [CNT_W-1:0]         count;
  logic                     push, pop, full;
  logic                     any_overlap, hazard;
  logic                     fwd_hit;
  logic [DATA_WIDTH-1:0]    fwd_data;
  logic [2:0]               ld_size;

  // Access size in bytes from funct3[1:0]: byte, half, otherwise word.
  function automatic logic [2:0] span_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Two byte spans overlap when either start lies inside the other span.
  // The subtraction wraps, so spans crossing all-ones are handled too.
  function automatic logic spans_overlap(input logic [ADDRESS_WIDTH-1:0] a,
                                         input logic [2:0]               sa,
                                         input logic [ADDRESS_WIDTH-1:0] b,
                                         input logic [2:0]               sb);
    logic [ADDRESS_WIDTH-1:0] d_ba;
    logic [ADDRESS_WIDTH-1:0] d_ab;
    d_ba = b - a;
    d_ab = a - b;
    return (d_ba < ADDRESS_WIDTH'(sa)) || (d_ab < ADDRESS_WIDTH'(sb));
  endfunction

  assign ld_size  = span_size(ld_funct3);
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign st_ready = (state == RUN) && !full;
  assign push     = st_valid && st_ready;

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0]         young_idx;
  logic [ADDRESS_WIDTH-1:0] fwd_off;
  logic                     fwd_cover;
  logic [DATA_WIDTH-1:0]    fwd_shifted;
`endif

  // Scan pending entries oldest to youngest for overlap with the load span.
  always_comb begin
    any_overlap = 1'b0;
    scan_idx    = head;
`ifdef STORE_FWD_EN
    young_idx   = head;
`endif
    for (int a = 0; a < DEPTH; a++) begin
      scan_idx = head + PTR_W'(a);
      if ((CNT_W'(a) < count) &&
          spans_overlap(entry_addr[scan_idx], span_size(entry_funct3[scan_idx]),
                        ld_addr, ld_size)) begin
        any_overlap = 1'b1;
`ifdef STORE_FWD_EN
        young_idx   = scan_idx;
`endif
      end
    end
  end

`ifdef STORE_FWD_EN
  // Forward when the youngest overlapping store holds every byte of the load.
  always_comb begin
    fwd_off     = ld_addr - entry_addr[young_idx];
    fwd_cover   = 1'b0;
    fwd_shifted = entry_data[young_idx] >> {fwd_off[1:0], 3'b000};
    fwd_data    = fwd_shifted;
    if (fwd_off < ADDRESS_WIDTH'(4)) begin
      fwd_cover = (({1'b0, fwd_off[2:0]} + {1'b0, ld_size}) <=
                   {1'b0, span_size(entry_funct3[young_idx])});
    end
    case (ld_funct3)
      3'b000:  fwd_data = {{(DATA_WIDTH-8){fwd_shifted[7]}}, fwd_shifted[7:0]};
      3'b001:  fwd_data = {{(DATA_WIDTH-16){fwd_shifted[15]}}, fwd_shifted[15:0]};
      3'b100:  fwd_data = {{(DATA_WIDTH-8){1'b0}}, fwd_shifted[7:0]};
      3'b101:  fwd_data = {{(DATA_WIDTH-16){1'b0}}, fwd_shifted[15:0]};
      default: fwd_data = fwd_shifted;
    endcase
    fwd_hit = ld_valid && any_overlap && fwd_cover;
    hazard  = ld_valid && any_overlap && !fwd_cover;
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  assign hazard   = ld_valid && any_overlap;
`endif

  // Memory port arbitration: loads first unless full, else drain the head.
  always_comb begin
    mem_addr   = entry_addr[head];
    mem_wdata  = entry_data[head];
    mem_funct3 = entry_funct3[head];
    mem_wr_en  = 1'b0;
    pop        = 1'b0;
    ld_stall   = ld_valid;
    ld_data    = mem_rdata;
    if (fwd_hit) begin
      ld_stall = 1'b0;
      ld_data  = fwd_data;
      if (!empty) begin
        mem_wr_en = 1'b1;
        pop       = 1'b1;
      end
    end else if (ld_valid && !hazard && !full) begin
      mem_addr   = ld_addr;
      mem_funct3 = ld_funct3;
      ld_stall   = 1'b0;
    end else if (!empty) begin
      mem_wr_en = 1'b1;
      pop       = 1'b1;
    end
  end

  // Entry storage needs no reset; validity comes from head and count.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[tail]   <= st_addr;
      entry_data[tail]   <= st_data;
      entry_funct3[tail] <= st_funct3;
    end
  end

  // Pointer and occupancy bookkeeping for the circular FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Fence state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Fence sequencing: block new stores until the last pending one pops.
  always_comb begin
    state_next = state;
    fence_done = 1'b0;
    case (state)
      RUN: begin
        if (fence_req) state_next = empty ? DONE : FENCE;
      end
      FENCE: begin
        if (pop && (count == CNT_W'(1))) state_next = DONE;
      end
      DONE: begin
        fence_done = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scoreboard bench for store_buffer.
// Stimulus queues expected memory writes and load results; a monitor on the
// falling edge compares them whenever the DUT writes memory or completes a load.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_funct3;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        fence_req, fence_done, empty;
  logic        mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] ld_q[$];
  wr_t         exp_wr;
  logic [31:0] exp_ld;
  int          done_cnt, done_at;
  logic        done_empty;

  store_buffer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_funct3(st_funct3),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .ld_data(ld_data), .ld_stall(ld_stall),
    .fence_req(fence_req), .fence_done(fence_done), .empty(empty),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Simple data_mem stand-in: read data is a fixed function of the address.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  assign mem_rdata = mem_model(mem_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs; an issued store queues its expected write.
  task automatic applyStimulus(input logic sv, input logic [31:0] sa,
                               input logic [31:0] sd, input logic [2:0] sf,
                               input logic lv, input logic [31:0] la,
                               input logic [2:0] lf, input logic fr);
    st_valid  = sv;
    st_addr   = sa;
    st_data   = sd;
    st_funct3 = sf;
    ld_valid  = lv;
    ld_addr   = la;
    ld_funct3 = lf;
    fence_req = fr;
    if (sv) wr_q.push_back({sa, sd, sf});
  endtask

  // Issue a load, hold it until it completes, and check the stall count.
  task automatic do_load(input string name, input logic [31:0] a,
                         input logic [2:0] f3, input logic [31:0] exp,
                         input int exp_stalls);
    int stalls = 0;
    bit done   = 1'b0;
    ld_q.push_back(exp);
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b0, 1'b1, a, f3, 1'b0);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!ld_stall) done = 1'b1;
      else begin
        stalls++;
        next_cycle();
      end
    end
    checkOutput({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    next_cycle();
    ld_valid = 1'b0;
  endtask

  // Wait a bounded number of cycles for the buffer to empty.
  task automatic wait_empty(input string name, input int max_cycles);
    int n = 0;
    @(negedge clk);
    while (!empty && n < max_cycles) begin
      next_cycle();
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_empty"}, 32'(empty), 32'd1);
    checkOutput({name, "_writes_left"}, 32'(wr_q.size()), 32'd0);
    next_cycle();
  endtask

  // Scoreboard monitor: compare memory writes and completed loads.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_en) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL mem_write: actual addr=%h data=%h required no write",
                   mem_addr, mem_wdata);
        end else begin
          exp_wr = wr_q.pop_front();
          if ({mem_addr, mem_wdata, mem_funct3} !== exp_wr) begin
            errors++;
            $display("[TB] FAIL mem_write: actual addr=%h data=%h f3=%b required addr=%h data=%h f3=%b",
                     mem_addr, mem_wdata, mem_funct3, exp_wr.addr, exp_wr.data, exp_wr.f3);
          end
        end
      end
      if (ld_valid && !ld_stall) begin
        checks++;
        if (ld_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL ld_result: actual=%h required no completion", ld_data);
        end else begin
          exp_ld = ld_q.pop_front();
          if (ld_data !== exp_ld) begin
            errors++;
            $display("[TB] FAIL ld_result: actual=%h required=%h", ld_data, exp_ld);
          end
        end
      end
    end
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b0, 1'b0, 32'h0, 3'b0, 1'b0);
    repeat (2) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_st_ready", 32'(st_ready), 32'd1);
    checkOutput("rst_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("rst_ld_stall", 32'(ld_stall), 32'd0);
    checkOutput("rst_fence_done", 32'(fence_done), 32'd0);
    next_cycle();

    // Single store reaches memory the cycle after acceptance.
    $display("[TB] single store drain");
    applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0, 3'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1_st_ready", 32'(st_ready), 32'd1);
    next_cycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b0, 1'b0, 32'h0, 3'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1_wr_en", 32'(mem_wr_en), 32'd1);
    next_cycle();
    @(negedge clk);
    checkOutput("t1_empty_after", 32'(empty), 32'd1);
    checkOutput("t1_wr_en_after", 32'(mem_wr_en), 32'd0);
    next_cycle();

    // Fill the buffer behind a stream of non-overlapping loads.
    $display("[TB] full buffer arbitration");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'h10 + 32'(4 * k), 32'hA000_0000 + 32'(k), 3'b010,
                    1'b1, 32'h200, 3'b010, 1'b0);
      ld_q.push_back(mem_model(32'h200));
      @(negedge clk);
      checkOutput("t2_ld_grant", 32'(ld_stall), 32'd0);
      next_cycle();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b0, 1'b1, 32'h200, 3'b010, 1'b0);
    ld_q.push_back(mem_model(32'h200));
    @(negedge clk);
    checkOutput("t2_full_st_ready", 32'(st_ready), 32'd0);
    checkOutput("t2_full_ld_stall", 32'(ld_stall), 32'd1);
    checkOutput("t2_full_wr_en", 32'(mem_wr_en), 32'd1);
    next_cycle();
    @(negedge clk);
    checkOutput("t2_after_ld_stall", 32'(ld_stall), 32'd0);
    checkOutput("t2_after_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("t2_after_st_ready", 32'(st_ready), 32'd1);
    checkOutput("t2_after_not_empty", 32'(empty), 32'd0);
    next_cycle();
    ld_valid = 1'b0;
    wait_empty("t2", 10);

    // Partially overlapping load stalls until the store drains.
    $display("[TB] overlapping load hazard");
    applyStimulus(1'b1, 32'h300, 32'h11223344, 3'b010, 1'b0, 32'h0, 3'b0, 1'b0);
    @(negedge clk);
    next_cycle();
    do_load("t3_partial", 32'h302, 3'b010, mem_model(32'h302), 1);
    wait_empty("t3", 10);

    // A store pushed in the same cycle does not block an overlapping load.
    $display("[TB] same-cycle store excluded");
    applyStimulus(1'b1, 32'h500, 32'h55667788, 3'b010, 1'b1, 32'h500, 3'b010, 1'b0);
    ld_q.push_back(mem_model(32'h500));
    @(negedge clk);
    checkOutput("t3b_ld_stall", 32'(ld_stall), 32'd0);
    next_cycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b0, 1'b0, 32'h0, 3'b0, 1'b0);
    wait_empty("t3b", 10);

    // Byte loads from a fully covering pending word store.
    $display("[TB] byte loads over pending store");
    applyStimulus(1'b1, 32'h3F0, 32'h0BADF00D, 3'b010, 1'b1, 32'h200, 3'b010, 1'b0);
    ld_q.push_back(mem_model(32'h200));
    @(negedge clk);
    next_cycle();
    applyStimulus(1'b1, 32'h400, 32'h808182F3, 3'b010, 1'b1, 32'h200, 3'b010, 1'b0);
    ld_q.push_back(mem_model(32'h200));
    @(negedge clk);
    next_cycle();
`ifdef STORE_FWD_EN
    do_load("t4_lb", 32'h400, 3'b000, 32'hFFFFFFF3, 0);
    do_load("t4_lbu", 32'h403, 3'b100, 32'h00000080, 0);
`else
    do_load("t4_lb", 32'h400, 3'b000, mem_model(32'h400), 2);
    do_load("t4_lbu", 32'h403, 3'b100, mem_model(32'h403), 0);
`endif
    wait_empty("t4", 10);

    // Fence with nothing pending completes on the next cycle.
    $display("[TB] fence on empty buffer");
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b0, 1'b0, 32'h0, 3'b0, 1'b1);
    @(negedge clk);
    checkOutput("t5a_done_early", 32'(fence_done), 32'd0);
    next_cycle();
    fence_req = 1'b0;
    @(negedge clk);
    checkOutput("t5a_done", 32'(fence_done), 32'd1);
    next_cycle();
    @(negedge clk);
    checkOutput("t5a_done_clear", 32'(fence_done), 32'd0);
    checkOutput("t5a_st_ready", 32'(st_ready), 32'd1);
    next_cycle();

    // Fence with three stores pending.
    $display("[TB] fence drain");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h20 + 32'(4 * k), 32'hC0 + 32'(k), 3'b010,
                    1'b1, 32'h200, 3'b010, 1'b0);
      ld_q.push_back(mem_model(32'h200));
      @(negedge clk);
      next_cycle();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b0, 1'b0, 32'h0, 3'b0, 1'b1);
    done_cnt   = 0;
    done_at    = -1;
    done_empty = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) checkOutput("t5_st_ready_fence", 32'(st_ready), 32'd0);
      if (fence_done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at    = c;
          done_empty = empty;
        end
      end
      next_cycle();
      fence_req = 1'b0;
    end
    checkOutput("t5_done_count", 32'(done_cnt), 32'd1);
    checkOutput("t5_done_cycle", 32'(done_at), 32'd3);
    checkOutput("t5_done_empty", 32'(done_empty), 32'd1);
    checkOutput("t5_writes_left", 32'(wr_q.size()), 32'd0);

    // Reset in the middle of a fence discards pending stores.
    $display("[TB] reset during fence");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 32'h30 + 32'(4 * k), 32'hE0 + 32'(k), 3'b010,
                    1'b1, 32'h200, 3'b010, 1'b0);
      ld_q.push_back(mem_model(32'h200));
      @(negedge clk);
      next_cycle();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b0, 1'b1, 32'h200, 3'b010, 1'b1);
    ld_q.push_back(mem_model(32'h200));
    @(negedge clk);
    checkOutput("t6_fence_ld_wins", 32'(mem_wr_en), 32'd0);
    next_cycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b0, 1'b0, 32'h0, 3'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_in_fence_st_ready", 32'(st_ready), 32'd0);
    next_cycle();
    rst = 1'b0;
    wr_q.delete();
    @(negedge clk);
    checkOutput("t6_empty", 32'(empty), 32'd1);
    checkOutput("t6_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("t6_fence_done", 32'(fence_done), 32'd0);
    checkOutput("t6_st_ready", 32'(st_ready), 32'd1);
    next_cycle();
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (fence_done) done_cnt++;
      next_cycle();
    end
    checkOutput("t6_no_fence_done", 32'(done_cnt), 32'd0);
    checkOutput("final_loads_left", 32'(ld_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
